// File: rtl/bsg_gateway_tag_pkg.sv
// Shared types and GPIO bit positions for the MicroBlaze tag command path.
package bsg_gateway_tag_pkg;

    localparam int PARITY   = 27;
    localparam int SOFT_RST = 26;
    localparam int TOGGLE   = 25;
    localparam int SEL_LSB  = 19;
    localparam int CNT_LSB  = 11;
    localparam int LOAD_LSB = 3;
    localparam int MODE_LSB = 0;

    typedef struct packed {
        logic [5:0] select;
        logic [7:0] counter;
        logic [7:0] load;
        logic [2:0] mode;
    } cmd_s;

    function automatic cmd_s gpio_to_cmd(input logic [TOGGLE-1:0] fields);
        cmd_s c;
        c.select  = fields[SEL_LSB  +: 6];
        c.counter = fields[CNT_LSB  +: 8];
        c.load    = fields[LOAD_LSB +: 8];
        c.mode    = fields[MODE_LSB +: 3];
        return c;
    endfunction

endpackage

// File: rtl/bsg_gateway_tag_cmd_fifo.sv
// Register FIFO of tag commands with valid/yumi handshake, occupancy count and flush.
module bsg_gateway_tag_cmd_fifo
    import bsg_gateway_tag_pkg::*;
#(
    parameter  int els_p    = 4,
    localparam int ptr_w_lp = $clog2(els_p),
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                flush_i,
    input  logic                v_i,
    input  cmd_s                data_i,
    output logic                v_o,
    output cmd_s                data_o,
    input  logic                yumi_i,
    output logic [cnt_w_lp-1:0] count_o
);

    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

    cmd_s                r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rptr;
    logic [ptr_w_lp-1:0] r_wptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_pop;

    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;
    assign w_pop   = yumi_i & v_o;

    // els_p is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (v_i) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + ptr_one_lp;
            end
            if (w_pop) r_rptr <= r_rptr + ptr_one_lp;
            case ({v_i, w_pop})
                2'b10:   r_count <= r_count + cnt_one_lp;
                2'b01:   r_count <= r_count - cnt_one_lp;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_gateway_tag_cmd_queue.sv
// Turns toggle-strobed tag GPIO writes into a queued valid/yumi command stream.
// Optional parity check enabled by defining BSG_GATEWAY_TAG_CMD_PARITY_EN.
module bsg_gateway_tag_cmd_queue
    import bsg_gateway_tag_pkg::*;
#(
    parameter  int els_p        = 4,
    parameter  int gpio_width_p = 32,
    localparam int cnt_w_lp     = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [gpio_width_p-1:0] gpio_i,
    output logic                    cmd_v_o,
    output cmd_s                    cmd_o,
    input  logic                    cmd_yumi_i,
    output logic                    tag_reset_o,
    output logic                    ack_toggle_o,
    output logic                    overflow_o,
    output logic                    parity_err_o,
    output logic [cnt_w_lp-1:0]     count_o
);

    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

    logic r_toggle;
    logic r_tag_reset;
    logic r_overflow;
    logic w_soft;
    logic w_edge;
    logic w_par_ok;
    logic w_space;
    logic w_enq;
    logic w_unused_gpio;

    assign w_soft  = gpio_i[SOFT_RST];
    assign w_edge  = (gpio_i[TOGGLE] != r_toggle) & ~w_soft;
    assign w_space = (count_o != full_lp) | cmd_yumi_i;
    assign w_enq   = w_edge & w_par_ok & w_space;

`ifdef BSG_GATEWAY_TAG_CMD_PARITY_EN
    logic r_parity_err;

    assign w_par_ok      = ~^gpio_i[PARITY:0];
    assign w_unused_gpio = ^gpio_i[gpio_width_p-1:PARITY+1];
    assign parity_err_o  = r_parity_err;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                r_parity_err <= 1'b0;
        else if (w_soft)               r_parity_err <= 1'b0;
        else if (w_edge && !w_par_ok)  r_parity_err <= 1'b1;
    end
`else
    assign w_par_ok      = 1'b1;
    assign w_unused_gpio = ^gpio_i[gpio_width_p-1:PARITY];
    assign parity_err_o  = 1'b0;
`endif

    // Toggle always follows the GPIO: a dropped or soft-reset-absorbed edge
    // still gets echoed so software never waits forever on the ack.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_toggle    <= 1'b0;
            r_tag_reset <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_toggle    <= gpio_i[TOGGLE];
            r_tag_reset <= w_soft;
            if (w_soft)                            r_overflow <= 1'b0;
            else if (w_edge && w_par_ok && !w_space) r_overflow <= 1'b1;
        end
    end

    assign tag_reset_o  = r_tag_reset;
    assign ack_toggle_o = r_toggle;
    assign overflow_o   = r_overflow;

    bsg_gateway_tag_cmd_fifo #(.els_p(els_p)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (w_soft),
        .v_i       (w_enq),
        .data_i    (gpio_to_cmd(gpio_i[TOGGLE-1:0])),
        .v_o       (cmd_v_o),
        .data_o    (cmd_o),
        .yumi_i    (cmd_yumi_i),
        .count_o   (count_o)
    );

`ifndef SYNTHESIS
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        cmd_yumi_i |-> cmd_v_o);
`endif

endmodule

// File: tb/tb_bsg_gateway_tag_cmd_queue.sv
// Directed bench for bsg_gateway_tag_cmd_queue (els_p=4); honours BSG_GATEWAY_TAG_CMD_PARITY_EN.
module tb_bsg_gateway_tag_cmd_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] gpio;
    logic        yumi;
    logic        cmd_v;
    logic [24:0] cmd;
    logic        tag_reset;
    logic        ack;
    logic        ovf;
    logic        perr;
    logic [2:0]  count;

    int   checks   = 0;
    int   failures = 0;
    logic tog      = 1'b0;

    always #5 clk = ~clk;

    bsg_gateway_tag_cmd_queue #(.els_p(4), .gpio_width_p(32)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .gpio_i       (gpio),
        .cmd_v_o      (cmd_v),
        .cmd_o        (cmd),
        .cmd_yumi_i   (yumi),
        .tag_reset_o  (tag_reset),
        .ack_toggle_o (ack),
        .overflow_o   (ovf),
        .parity_err_o (perr),
        .count_o      (count)
    );

    // GPIO word with even overall parity over bits [27:0]
    function automatic logic [31:0] mk(input logic t, input logic sr, input logic [24:0] c);
        logic [31:0] w;
        w     = {4'b0, 1'b0, sr, t, c};
        w[27] = ^w[26:0];
        return w;
    endfunction

    function automatic logic [24:0] pat(input int i);
        return {6'(i + 1), 8'(8'h20 + i), 8'(8'hC0 ^ i), 3'(i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] c);
        tog  = ~tog;
        gpio = mk(tog, 1'b0, c);
        step();
    endtask

    task automatic pop();
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        gpio    = '0;
        yumi    = 1'b0;
        tog     = 1'b0;
        step();
        step();
        checks++; if ({cmd_v, cmd, tag_reset, ack, ovf, perr, count} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {cmd_v, cmd, tag_reset, ack, ovf, perr, count});
        end
        reset_n = 1'b1;
        step();
        checks++; if (count !== 3'd0 || cmd_v !== 1'b0) begin
            failures++; $display("FAIL reset_release count=%0d v=%0b exp=0/0", count, cmd_v);
        end
    endtask

    task automatic test_basic();
        send({6'h2A, 8'h10, 8'hA5, 3'd3});
        checks++; if (cmd_v !== 1'b1) begin failures++; $display("FAIL basic_v got=%0b exp=1", cmd_v); end
        checks++; if (cmd !== {6'h2A, 8'h10, 8'hA5, 3'd3}) begin
            failures++; $display("FAIL basic_cmd got=%h exp=%h", cmd, {6'h2A, 8'h10, 8'hA5, 3'd3});
        end
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%0b exp=1", ack); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
        pop();
        checks++; if (cmd_v !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL basic_pop v=%0b count=%0d exp=0/0", cmd_v, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) send(pat(i));
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%0b exp=1", ovf); end
        checks++; if (ack !== tog) begin failures++; $display("FAIL fill_ack got=%0b exp=%0b", ack, tog); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_v !== 1'b1 || cmd !== pat(i)) begin
                failures++; $display("FAIL fill_drain%0d v=%0b got=%h exp=%h", i, cmd_v, cmd, pat(i));
            end
            pop();
        end
        checks++; if (cmd_v !== 1'b0 || count !== 3'd0 || ovf !== 1'b1) begin
            failures++; $display("FAIL fill_empty v=%0b count=%0d ovf=%0b exp=0/0/1", cmd_v, count, ovf);
        end
    endtask

    task automatic test_soft_reset();
        for (int i = 0; i < 3; i++) send(pat(10 + i));
        checks++; if (count !== 3'd3 || ovf !== 1'b1) begin
            failures++; $display("FAIL sr_pre count=%0d ovf=%0b exp=3/1", count, ovf);
        end
        tog  = ~tog;
        gpio = mk(tog, 1'b1, pat(20));
        step();
        checks++; if (count !== 3'd0 || cmd_v !== 1'b0 || ovf !== 1'b0 || perr !== 1'b0) begin
            failures++; $display("FAIL sr_flush count=%0d v=%0b ovf=%0b perr=%0b exp=0/0/0/0", count, cmd_v, ovf, perr);
        end
        checks++; if (tag_reset !== 1'b1) begin failures++; $display("FAIL sr_tag1 got=%0b exp=1", tag_reset); end
        tog  = ~tog;
        gpio = mk(tog, 1'b1, pat(21));
        step();
        checks++; if (tag_reset !== 1'b1 || count !== 3'd0 || ack !== tog) begin
            failures++; $display("FAIL sr_hold tag=%0b count=%0d ack=%0b exp=1/0/%0b", tag_reset, count, ack, tog);
        end
        gpio = mk(tog, 1'b0, pat(21));
        step();
        checks++; if (tag_reset !== 1'b0 || count !== 3'd0 || cmd_v !== 1'b0) begin
            failures++; $display("FAIL sr_release tag=%0b count=%0d v=%0b exp=0/0/0", tag_reset, count, cmd_v);
        end
    endtask

    task automatic test_full_yumi();
        for (int i = 0; i < 4; i++) send(pat(30 + i));
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fy_fill got=%0d exp=4", count); end
        tog  = ~tog;
        gpio = mk(tog, 1'b0, pat(34));
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        checks++; if (count !== 3'd4 || ovf !== 1'b0) begin
            failures++; $display("FAIL fy_same count=%0d ovf=%0b exp=4/0", count, ovf);
        end
        for (int i = 1; i < 5; i++) begin
            checks++; if (cmd_v !== 1'b1 || cmd !== pat(30 + i)) begin
                failures++; $display("FAIL fy_drain%0d v=%0b got=%h exp=%h", i, cmd_v, cmd, pat(30 + i));
            end
            pop();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            send(pat(40 + i));
            checks++; if (cmd_v !== 1'b1 || cmd !== pat(40 + i)) begin
                failures++; $display("FAIL wrap%0d v=%0b got=%h exp=%h", i, cmd_v, cmd, pat(40 + i));
            end
            pop();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    endtask

    task automatic test_parity();
        logic [31:0] w;
        tog  = ~tog;
        w    = mk(tog, 1'b0, pat(50));
        w[27] = ~w[27];
        gpio = w;
        step();
`ifdef BSG_GATEWAY_TAG_CMD_PARITY_EN
        checks++; if (count !== 3'd0 || perr !== 1'b1 || ack !== tog) begin
            failures++; $display("FAIL par_odd count=%0d perr=%0b ack=%0b exp=0/1/%0b", count, perr, ack, tog);
        end
        send(pat(51));
        checks++; if (count !== 3'd1 || cmd !== pat(51) || perr !== 1'b1) begin
            failures++; $display("FAIL par_even count=%0d cmd=%h perr=%0b exp=1/%h/1", count, cmd, perr, pat(51));
        end
        pop();
`else
        checks++; if (count !== 3'd1 || cmd !== pat(50) || perr !== 1'b0) begin
            failures++; $display("FAIL par_ignored count=%0d cmd=%h perr=%0b exp=1/%h/0", count, cmd, perr, pat(50));
        end
        pop();
`endif
    endtask

    task automatic test_async_reset();
        send(pat(60));
        send(pat(61));
        tog  = ~tog;
        gpio = mk(tog, 1'b0, pat(62));
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({cmd_v, cmd, tag_reset, ack, ovf, perr, count} !== '0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {cmd_v, cmd, tag_reset, ack, ovf, perr, count});
        end
        gpio = '0;
        tog  = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (count !== 3'd0 || cmd_v !== 1'b0) begin
            failures++; $display("FAIL async_release count=%0d v=%0b exp=0/0", count, cmd_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_soft_reset();
        test_full_yumi();
        test_wrap();
        test_parity();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
